// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline control slice: stage indices,
// FSM state encoding, forward-select codes and the per-situation stall/bubble patterns.
package pipe_ctrl_pkg;

    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_MDU_WAIT = 2'b10,
        ST_FLUSH    = 2'b11
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    localparam logic [4:0] STG_BIT_F = 5'(1 << STG_F);
    localparam logic [4:0] STG_BIT_D = 5'(1 << STG_D);
    localparam logic [4:0] STG_BIT_E = 5'(1 << STG_E);
    localparam logic [4:0] STG_BIT_M = 5'(1 << STG_M);
    localparam logic [4:0] STG_BIT_W = 5'(1 << STG_W);

    // Memory wait freezes F..M and drains W; MDU wait freezes F..E and drains M.
    localparam logic [4:0] STALL_MEM    = STG_BIT_F | STG_BIT_D | STG_BIT_E | STG_BIT_M;
    localparam logic [4:0] BUBBLE_MEM   = STG_BIT_W;
    localparam logic [4:0] STALL_MDU    = STG_BIT_F | STG_BIT_D | STG_BIT_E;
    localparam logic [4:0] BUBBLE_MDU   = STG_BIT_M;
    localparam logic [4:0] STALL_HAZ    = STG_BIT_F | STG_BIT_D;
    localparam logic [4:0] BUBBLE_HAZ   = STG_BIT_E;
    localparam logic [4:0] BUBBLE_REDIR = STG_BIT_D;
    localparam logic [4:0] BUBBLE_FLUSH = STG_BIT_D | STG_BIT_E | STG_BIT_M;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding select and raw producer-match flags.
// Register x0 and unused operands never match anything.
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_use,
    input  logic [REG_AW-1:0] e_rd,
    input  logic              e_wen,
    input  logic              e_load,
    input  logic [REG_AW-1:0] m_rd,
    input  logic              m_wen,
    input  logic [REG_AW-1:0] w_rd,
    input  logic              w_wen,
    output logic [1:0]        fwd_sel,
    output logic              e_match,
    output logic              m_match
);

    logic src_ok;
    logic w_match;

    assign src_ok  = rs_use && (rs != '0);
    assign e_match = src_ok && e_wen && (e_rd == rs);
    assign m_match = src_ok && m_wen && (m_rd == rs);
    assign w_match = src_ok && w_wen && (w_rd == rs);

    // A load in E has no data yet, so the select falls through to older producers.
    always_comb begin
        if (e_match && !e_load) fwd_sel = FWD_E;
        else if (m_match)       fwd_sel = FWD_M;
        else if (w_match)       fwd_sel = FWD_W;
        else                    fwd_sel = FWD_RF;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding selects, wait/flush FSM and memory-wait watchdog.
// Optional PIPE_PERF_CNT_EN adds stall-cycle and flush-cycle counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] d_rs1_i,
    input  logic [REG_AW-1:0] d_rs2_i,
    input  logic              d_rs1_use_i,
    input  logic              d_rs2_use_i,
    input  logic              d_br_use_i,
    input  logic              d_redirect_i,
    input  logic [REG_AW-1:0] e_rd_i,
    input  logic              e_wen_i,
    input  logic              e_load_i,
    input  logic              e_mdu_start_i,
    input  logic [REG_AW-1:0] m_rd_i,
    input  logic              m_wen_i,
    input  logic              m_load_i,
    input  logic              m_mem_req_i,
    input  logic              m_mem_ready_i,
    input  logic [REG_AW-1:0] w_rd_i,
    input  logic              w_wen_i,
    input  logic              mdu_done_i,
    input  logic              trap_i,
    output logic [4:0]        stall_o,
    output logic [4:0]        bubble_o,
    output logic [1:0]        fwd_rs1_o,
    output logic [1:0]        fwd_rs2_o,
    output logic              flush_o,
    output logic              mem_timeout_o,
    output logic [1:0]        state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o
`endif
);

    localparam int WD_W = $clog2(MAX_WAIT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_WAIT);

    state_e          state;
    logic            trap_pend;
    logic [WD_W-1:0] wd_cnt;

    logic [1:0] fwd1, fwd2;
    logic       rs1_e_match, rs1_m_match, rs2_e_match, rs2_m_match;
    logic       load_use, br_haz, hazard;
    logic       mem_block, mdu_block, timeout;
    logic [4:0] stall_c, bubble_c;
    logic       flush_c;

    pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .rs      (d_rs1_i),
        .rs_use  (d_rs1_use_i),
        .e_rd    (e_rd_i),
        .e_wen   (e_wen_i),
        .e_load  (e_load_i),
        .m_rd    (m_rd_i),
        .m_wen   (m_wen_i),
        .w_rd    (w_rd_i),
        .w_wen   (w_wen_i),
        .fwd_sel (fwd1),
        .e_match (rs1_e_match),
        .m_match (rs1_m_match)
    );

    pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .rs      (d_rs2_i),
        .rs_use  (d_rs2_use_i),
        .e_rd    (e_rd_i),
        .e_wen   (e_wen_i),
        .e_load  (e_load_i),
        .m_rd    (m_rd_i),
        .m_wen   (m_wen_i),
        .w_rd    (w_rd_i),
        .w_wen   (w_wen_i),
        .fwd_sel (fwd2),
        .e_match (rs2_e_match),
        .m_match (rs2_m_match)
    );

    // Branches read operands in D, so any E producer or an M load is too late to forward.
    assign load_use  = (rs1_e_match || rs2_e_match) && e_load_i;
    assign br_haz    = d_br_use_i && ((rs1_e_match || rs2_e_match) ||
                                      ((rs1_m_match || rs2_m_match) && m_load_i));
    assign hazard    = load_use || br_haz;
    assign mem_block = m_mem_req_i && !m_mem_ready_i;
    assign mdu_block = e_mdu_start_i && !mdu_done_i;
    assign timeout   = (state == ST_MEM_WAIT) && (wd_cnt == WD_MAX);

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        stall_c  = '0;
        bubble_c = '0;
        flush_c  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (trap_i) begin
                    stall_c = '0;
                end else if (mem_block) begin
                    stall_c  = STALL_MEM;
                    bubble_c = BUBBLE_MEM;
                end else if (mdu_block) begin
                    stall_c  = STALL_MDU;
                    bubble_c = BUBBLE_MDU;
                end else if (hazard) begin
                    stall_c  = STALL_HAZ;
                    bubble_c = BUBBLE_HAZ;
                end else if (d_redirect_i) begin
                    bubble_c = BUBBLE_REDIR;
                end
            end
            ST_MEM_WAIT: begin
                if (timeout || (m_mem_ready_i && (trap_pend || trap_i))) begin
                    stall_c = '0;
                end else if (!m_mem_ready_i) begin
                    stall_c  = STALL_MEM;
                    bubble_c = BUBBLE_MEM;
                end else if (hazard) begin
                    stall_c  = STALL_HAZ;
                    bubble_c = BUBBLE_HAZ;
                end else if (d_redirect_i) begin
                    bubble_c = BUBBLE_REDIR;
                end
            end
            ST_MDU_WAIT: begin
                if (trap_i) begin
                    stall_c = '0;
                end else if (!mdu_done_i) begin
                    stall_c  = STALL_MDU;
                    bubble_c = BUBBLE_MDU;
                end else if (hazard) begin
                    stall_c  = STALL_HAZ;
                    bubble_c = BUBBLE_HAZ;
                end else if (d_redirect_i) begin
                    bubble_c = BUBBLE_REDIR;
                end
            end
            ST_FLUSH: begin
                bubble_c = BUBBLE_FLUSH;
                flush_c  = 1'b1;
            end
            default: stall_c = '0;
        endcase
    end

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    assign stall_o       = rst_n ? stall_c : '0;
    assign bubble_o      = rst_n ? bubble_c : '0;
    assign flush_o       = rst_n && flush_c;
    assign mem_timeout_o = rst_n && timeout;
    assign fwd_rs1_o     = rst_n ? fwd1 : FWD_RF;
    assign fwd_rs2_o     = rst_n ? fwd2 : FWD_RF;
    assign state_o       = state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            trap_pend <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    wd_cnt <= '0;
                    if (trap_i)         state <= ST_FLUSH;
                    else if (mem_block) state <= ST_MEM_WAIT;
                    else if (mdu_block) state <= ST_MDU_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (timeout) begin
                        state     <= ST_FLUSH;
                        trap_pend <= 1'b0;
                        wd_cnt    <= '0;
                    end else if (m_mem_ready_i) begin
                        state     <= (trap_pend || trap_i) ? ST_FLUSH : ST_RUN;
                        trap_pend <= 1'b0;
                        wd_cnt    <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (trap_i) trap_pend <= 1'b1;
                    end
                end
                ST_MDU_WAIT: begin
                    if (trap_i)          state <= ST_FLUSH;
                    else if (mdu_done_i) state <= ST_RUN;
                end
                ST_FLUSH: begin
                    state <= trap_i ? ST_FLUSH : ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (stall_o[STG_F]) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (flush_c)        perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (watchdog limit set to 4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] d_rs1_i, d_rs2_i, e_rd_i, m_rd_i, w_rd_i;
    logic       d_rs1_use_i, d_rs2_use_i, d_br_use_i, d_redirect_i;
    logic       e_wen_i, e_load_i, e_mdu_start_i;
    logic       m_wen_i, m_load_i, m_mem_req_i, m_mem_ready_i;
    logic       w_wen_i, mdu_done_i, trap_i;
    logic [4:0] stall_o, bubble_o;
    logic [1:0] fwd_rs1_o, fwd_rs2_o, state_o;
    logic       flush_o, mem_timeout_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .MAX_WAIT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .d_rs1_i       (d_rs1_i),
        .d_rs2_i       (d_rs2_i),
        .d_rs1_use_i   (d_rs1_use_i),
        .d_rs2_use_i   (d_rs2_use_i),
        .d_br_use_i    (d_br_use_i),
        .d_redirect_i  (d_redirect_i),
        .e_rd_i        (e_rd_i),
        .e_wen_i       (e_wen_i),
        .e_load_i      (e_load_i),
        .e_mdu_start_i (e_mdu_start_i),
        .m_rd_i        (m_rd_i),
        .m_wen_i       (m_wen_i),
        .m_load_i      (m_load_i),
        .m_mem_req_i   (m_mem_req_i),
        .m_mem_ready_i (m_mem_ready_i),
        .w_rd_i        (w_rd_i),
        .w_wen_i       (w_wen_i),
        .mdu_done_i    (mdu_done_i),
        .trap_i        (trap_i),
        .stall_o       (stall_o),
        .bubble_o      (bubble_o),
        .fwd_rs1_o     (fwd_rs1_o),
        .fwd_rs2_o     (fwd_rs2_o),
        .flush_o       (flush_o),
        .mem_timeout_o (mem_timeout_o),
        .state_o       (state_o)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d_rs1_i = '0; d_rs2_i = '0; e_rd_i = '0; m_rd_i = '0; w_rd_i = '0;
        d_rs1_use_i = 0; d_rs2_use_i = 0; d_br_use_i = 0; d_redirect_i = 0;
        e_wen_i = 0; e_load_i = 0; e_mdu_start_i = 0;
        m_wen_i = 0; m_load_i = 0; m_mem_req_i = 0; m_mem_ready_i = 0;
        w_wen_i = 0; mdu_done_i = 0; trap_i = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        // Reset: a redirect and a load-use pattern on the inputs must not leak out.
        d_redirect_i = 1; e_rd_i = 5'd3; e_wen_i = 1; e_load_i = 1; d_rs1_i = 5'd3; d_rs1_use_i = 1;
        #2;
        check("rst_state",  state_o,  2'b00);
        check("rst_stall",  stall_o,  5'b00000);
        check("rst_bubble", bubble_o, 5'b00000);
        check("rst_flush",  flush_o,  1'b0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();

        // Load-use on x5, then forward from M.
        e_rd_i = 5'd5; e_wen_i = 1; e_load_i = 1; d_rs1_i = 5'd5; d_rs1_use_i = 1;
        #1;
        check("lu_stall",  stall_o,   5'b00011);
        check("lu_bubble", bubble_o,  5'b00100);
        check("lu_fwd",    fwd_rs1_o, 2'b00);
        tick();
        e_rd_i = '0; e_wen_i = 0; e_load_i = 0; m_rd_i = 5'd5; m_wen_i = 1; m_load_i = 1;
        #1;
        check("lu_after_stall", stall_o,   5'b00000);
        check("lu_after_fwd",   fwd_rs1_o, 2'b10);
        clear_inputs();

        // Same pattern on x0 never stalls.
        e_rd_i = 5'd0; e_wen_i = 1; e_load_i = 1; d_rs1_i = 5'd0; d_rs1_use_i = 1;
        #1;
        check("x0_stall", stall_o,   5'b00000);
        check("x0_fwd",   fwd_rs1_o, 2'b00);
        clear_inputs();

        // Forwarding priority on x7.
        e_rd_i = 5'd7; m_rd_i = 5'd7; w_rd_i = 5'd7; e_wen_i = 1; m_wen_i = 1; w_wen_i = 1;
        d_rs1_i = 5'd7; d_rs2_i = 5'd7; d_rs1_use_i = 1; d_rs2_use_i = 1;
        #1;
        check("fwd_all_rs1", fwd_rs1_o, 2'b01);
        check("fwd_all_rs2", fwd_rs2_o, 2'b01);
        check("fwd_all_stall", stall_o, 5'b00000);
        e_wen_i = 0;
        #1;
        check("fwd_mw_rs2", fwd_rs2_o, 2'b10);
        m_wen_i = 0;
        #1;
        check("fwd_w_rs1", fwd_rs1_o, 2'b11);
        d_rs2_use_i = 0;
        #1;
        check("fwd_nouse_rs2", fwd_rs2_o, 2'b00);
        clear_inputs();

        // Branch operand hazards and redirects.
        e_rd_i = 5'd9; e_wen_i = 1; d_rs2_i = 5'd9; d_rs2_use_i = 1; d_br_use_i = 1;
        #1;
        check("br_e_stall", stall_o, 5'b00011);
        check("br_e_fwd",   fwd_rs2_o, 2'b01);
        clear_inputs();
        m_rd_i = 5'd4; m_wen_i = 1; m_load_i = 1; d_rs1_i = 5'd4; d_rs1_use_i = 1; d_br_use_i = 1;
        #1;
        check("br_mload_stall", stall_o, 5'b00011);
        d_br_use_i = 0;
        #1;
        check("nobr_mload_stall", stall_o, 5'b00000);
        clear_inputs();
        d_redirect_i = 1;
        #1;
        check("redir_bubble", bubble_o, 5'b00010);
        check("redir_stall",  stall_o,  5'b00000);
        e_rd_i = 5'd5; e_wen_i = 1; e_load_i = 1; d_rs1_i = 5'd5; d_rs1_use_i = 1;
        #1;
        check("redir_lu_bubble", bubble_o, 5'b00100);
        clear_inputs();

        // Memory wait: ready low for 3 cycles, high on the 4th.
        m_mem_req_i = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("mw_stall_%0d", c),  stall_o,  5'b01111);
            check($sformatf("mw_bubble_%0d", c), bubble_o, 5'b10000);
            check($sformatf("mw_state_%0d", c),  state_o,  (c == 0) ? 2'b00 : 2'b01);
            tick();
        end
        m_mem_ready_i = 1;
        #1;
        check("mw_ready_state", state_o, 2'b01);
        check("mw_ready_stall", stall_o, 5'b00000);
        tick();
        clear_inputs();
        #1;
        check("mw_exit_state", state_o, 2'b00);

        // MDU: start, done four cycles later.
        e_mdu_start_i = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("mdu_stall_%0d", c),  stall_o,  5'b00111);
            check($sformatf("mdu_bubble_%0d", c), bubble_o, 5'b01000);
            tick();
        end
        check("mdu_state", state_o, 2'b10);
        mdu_done_i = 1;
        #1;
        check("mdu_done_stall", stall_o, 5'b00000);
        tick();
        clear_inputs();
        #1;
        check("mdu_exit_state", state_o, 2'b00);

        // Trap during memory wait: held until ready, then one flush cycle.
        m_mem_req_i = 1;
        tick();
        trap_i = 1;
        #1;
        check("tmw_trap_stall", stall_o, 5'b01111);
        tick();
        trap_i = 0;
        #1;
        check("tmw_hold_state", state_o, 2'b01);
        check("tmw_hold_stall", stall_o, 5'b01111);
        tick();
        m_mem_ready_i = 1;
        #1;
        check("tmw_ready_stall", stall_o, 5'b00000);
        tick();
        clear_inputs();
        #1;
        check("tmw_flush_state",  state_o,  2'b11);
        check("tmw_flush",        flush_o,  1'b1);
        check("tmw_flush_bubble", bubble_o, 5'b01110);
        check("tmw_flush_stall",  stall_o,  5'b00000);
        tick();
        check("tmw_run_state", state_o, 2'b00);
        check("tmw_run_flush", flush_o, 1'b0);

        // Trap in RUN, and again during FLUSH.
        trap_i = 1;
        tick();
        check("trap_flush1", state_o, 2'b11);
        tick();
        check("trap_flush2", state_o, 2'b11);
        trap_i = 0;
        tick();
        check("trap_run", state_o, 2'b00);

        // Watchdog: ready never rises.
        m_mem_req_i = 1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("wd_quiet_%0d", c), mem_timeout_o, 1'b0);
            tick();
        end
        check("wd_pulse",       mem_timeout_o, 1'b1);
        check("wd_pulse_state", state_o,       2'b01);
        tick();
        m_mem_req_i = 0;
        #1;
        check("wd_flush_state", state_o,       2'b11);
        check("wd_flush",       flush_o,       1'b1);
        check("wd_pulse_gone",  mem_timeout_o, 1'b0);
        tick();
        check("wd_run_state", state_o, 2'b00);

        // Reset asserted mid-wait.
        m_mem_req_i = 1;
        tick();
        tick();
        check("rmw_state_before", state_o, 2'b01);
        d_redirect_i = 1;
        rst_n = 1'b0;
        #1;
        check("rmw_state",  state_o,  2'b00);
        check("rmw_stall",  stall_o,  5'b00000);
        check("rmw_bubble", bubble_o, 5'b00000);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        check("rmw_after", state_o, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Second-generation hazard and pipeline-control unit for the 5-stage core (F/D/E/M/W).
- Adds operand-forwarding selects, x0 exclusion, multi-cycle memory-wait and MDU-wait freezing, trap flush sequencing, and a memory-wait watchdog.
- Drives per-stage stall/bubble vectors for the pipeline registers from a small registered FSM plus combinational hazard detection.

Parameters:
- REG_AW, 5, register-address width.
- MAX_WAIT, 15, cycles spent in MEM_WAIT before the watchdog fires; must be ≥1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- d_rs1_i  in  REG_AW  D-stage source 1 address
- d_rs2_i  in  REG_AW  D-stage source 2 address
- d_rs1_use_i  in  1  D instruction reads rs1
- d_rs2_use_i  in  1  D instruction reads rs2
- d_br_use_i  in  1  D instruction consumes its operands in D (branch/jalr)
- d_redirect_i  in  1  taken branch/jump resolved in D
- e_rd_i  in  REG_AW  E destination
- e_wen_i  in  1  E writes rd
- e_load_i  in  1  E is a load
- e_mdu_start_i  in  1  E issues a multi-cycle MUL/DIV
- m_rd_i  in  REG_AW  M destination
- m_wen_i  in  1  M writes rd
- m_load_i  in  1  M is a load
- m_mem_req_i  in  1  M has an outstanding data-memory request
- m_mem_ready_i  in  1  data memory completes this cycle
- w_rd_i  in  REG_AW  W destination
- w_wen_i  in  1  W writes rd
- mdu_done_i  in  1  MDU result valid
- trap_i  in  1  exception/interrupt taken (W)
- stall_o  out  5  hold stage register; bit 0=F(pc), 1=D, 2=E, 3=M, 4=W
- bubble_o  out  5  insert NOP into stage register (same indexing)
- fwd_rs1_o  out  2  00 regfile, 01 E, 10 M, 11 W
- fwd_rs2_o  out  2  same encoding
- flush_o  out  1  trap flush cycle; also cancels MDU
- mem_timeout_o  out  1  one-cycle watchdog pulse
- state_o  out  2  FSM state, for debug

Behaviour:
- rst_n low: state RUN, watchdog counter 0, trap_pend 0. All outputs 0 while rst_n is low. Outputs are combinational from state and inputs.
- Hazard match requires a nonzero address, a matching rd, and the producer's wen. x0 never matches.
- Forwarding priority per source: E (only if !e_load_i) > M > W > regfile. The select is 00 when the use bit is 0.
- Load-use: D source matches E rd and e_load_i. Result: stall_o[1:0]=11, bubble_o[2]=1 for 1 cycle.
- Branch-operand hazard: d_br_use_i and a D source matches E rd (any producer), or matches M rd with m_load_i. Result: same stall/bubble as load-use.
- d_redirect_i with no stall: bubble_o[1]=1. A stall overrides the redirect; the redirect is re-evaluated next cycle.
- FSM states RUN(00), MEM_WAIT(01), MDU_WAIT(10), FLUSH(11).
- RUN → MEM_WAIT when m_mem_req_i & !m_mem_ready_i.
  - In MEM_WAIT, including the entry cycle: stall_o=01111, bubble_o=10000.
  - Exit to RUN on the m_mem_ready_i cycle; that cycle is unstalled.
- RUN → MDU_WAIT on e_mdu_start_i & !mdu_done_i.
  - In MDU_WAIT, including the start cycle: stall_o=00111, bubble_o=01000.
  - mdu_done_i releases the stall combinationally in the same cycle and returns to RUN.
- Priority: trap > MEM_WAIT > MDU_WAIT > load-use/branch hazard > redirect.
- trap_i in RUN or MDU_WAIT: next state FLUSH.
- trap_i in MEM_WAIT: set trap_pend. The memory access is never aborted. On ready, go to FLUSH and clear trap_pend.
- FLUSH lasts exactly 1 cycle: flush_o=1, bubble_o=01110, stall_o=0, then RUN. trap_i during FLUSH re-enters FLUSH.
- Watchdog counter: increments each MEM_WAIT cycle and clears on exit.
  - When it reaches MAX_WAIT: mem_timeout_o=1 for 1 cycle, treated as a trap, next state FLUSH, counter cleared.
  - Counter width is $clog2(MAX_WAIT+1).
- Asynchronous reset mid-wait: state returns to RUN immediately; no pending trap is retained.

Optional Feature:
- PIPE_PERF_CNT_EN defined: adds outputs perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_stall_cnt_o counts cycles with stall_o[0]=1.
  - perf_flush_cnt_o counts FLUSH cycles.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - stage index constants STG_F..STG_W;
  - FSM state typedef and encodings;
  - forward-select constants FWD_RF/FWD_E/FWD_M/FWD_W.
- One natural sub-module: pipe_fwd_sel. It is combinational, one instance per source operand, computes the forward select and the raw match flags, and is instantiated twice.

Test Plan:
- Load-use: E load x5, D add reading x5 → stall_o=00011, bubble_o=00100 for 1 cycle, then fwd_rs1_o=10. The same sequence with x0 → no stall.
- Forwarding: E/M/W all write x7, D reads x7 → fwd=01. With only W writing → fwd=11.
- Memory wait: m_mem_req_i=1 and ready low for 3 cycles → state_o=01, stall_o=01111, bubble_o=10000 for 3 cycles. Ready on the 4th cycle → RUN, no stall.
- MDU: start, done 4 cycles later → stall_o=00111 on 4 cycles; the done cycle has stall 0.
- Trap during MEM_WAIT: trap_i pulsed in wait cycle 1, ready at cycle 3 → FLUSH at cycle 4: flush_o=1, bubble_o=01110.
- Watchdog: MAX_WAIT=4, ready never rises → mem_timeout_o pulses after 4 wait cycles, then FLUSH, then RUN. Assert rst_n mid-wait → all outputs 0 immediately.
